// File: rtl/tohost_console_if.sv
`default_nettype none
// ============================================================================
//  Module   : tohost_console_if
//  Purpose  : Bundles the tohost write port, the UART TX handshake and the
//             console status outputs of tohost_console.
//  Ports    : master - core/UART side (drives WE, WDATA, TX_READY)
//             slave  - the console (drives TX_DATA, TX_WE and status)
//  Revision : 1.0 - initial release
// ============================================================================
interface tohost_console_if #(
  parameter int CNT_W = 16
);
  logic             WE;
  logic [31:0]      WDATA;
  logic             TX_READY;
  logic [7:0]       TX_DATA;
  logic             TX_WE;
  logic             HALTED;
  logic             DONE;
  logic [15:0]      EXIT_CODE;
  logic             FULL;
  logic             EMPTY;
  logic [CNT_W-1:0] DROP_CNT;

  modport master (
    output WE, WDATA, TX_READY,
    input  TX_DATA, TX_WE, HALTED, DONE, EXIT_CODE, FULL, EMPTY, DROP_CNT
  );

  modport slave (
    input  WE, WDATA, TX_READY,
    output TX_DATA, TX_WE, HALTED, DONE, EXIT_CODE, FULL, EMPTY, DROP_CNT
  );
endinterface
`default_nettype wire

// File: rtl/tohost_console.sv
`default_nettype none
// ============================================================================
//  Module   : tohost_console
//  Purpose  : Decodes tohost MMIO writes, queues print characters in a byte
//             FIFO and drains them one at a time into a UART TX port.
//             Latches the exit code of the halt command and raises DONE once
//             every queued character has been handed to the UART.
//  Ports    : CLK   - system clock, rising edge
//             RST_X - asynchronous active-low reset
//             bus   - tohost_console_if.slave (WE/WDATA in, TX handshake,
//                     HALTED/DONE/EXIT_CODE/FULL/EMPTY/DROP_CNT out)
//  Revision : 1.0 - initial release
// ============================================================================
module tohost_console #(
  parameter int QUEUE_SIZE = 64,
  parameter int CNT_W      = 16
) (
  input  logic                   CLK,
  input  logic                   RST_X,
  tohost_console_if.slave        bus
);

  localparam int           AW         = $clog2(QUEUE_SIZE);
  localparam logic [AW:0]  FULL_COUNT = QUEUE_SIZE[AW:0];

  localparam logic [1:0]   CMD_PRINT  = 2'd1;
  localparam logic [1:0]   CMD_HALT   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [7:0]        mem [QUEUE_SIZE];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  logic [7:0]        tx_data;
  logic              tx_we;
  logic              halted;
  logic              done;
  logic [15:0]       exit_code;
  logic [CNT_W-1:0]  drop_cnt;

  logic              full;
  logic              empty;
  logic              accept;
  logic [1:0]        cmd;
  logic              push_req;
  logic              push;
  logic              drop;
  logic              pop;
  logic              unused_wdata;

  assign unused_wdata = ^bus.WDATA[31:18];

  // FULL is the pre-pop occupancy, so a push racing a pop on a full FIFO
  // is still dropped.
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);

  assign accept   = bus.WE && !halted;
  assign cmd      = bus.WDATA[17:16];
  assign push_req = accept && (cmd == CMD_PRINT);
  assign push     = push_req && !full;
  assign drop     = push_req && full;

  // --------------------------------------------------------------------------
  // Drain FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Drain FSM: next state and pop decision
  // GUARD absorbs the UART's latency in dropping TX_READY after a send, so
  // WAIT never sees a stale READY from before the strobe.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && bus.TX_READY) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND:    state_next = GUARD;
      GUARD:   state_next = WAIT;
      WAIT: begin
        if (bus.TX_READY) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO storage: deliberately not reset
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= bus.WDATA[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy, TX register, status
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tx_data   <= 8'h00;
      tx_we     <= 1'b0;
      halted    <= 1'b0;
      done      <= 1'b0;
      exit_code <= 16'h0000;
      drop_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        tx_data <= mem[rd_ptr];
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Strobe is high exactly for the SEND cycle.
      tx_we <= (state_next == SEND);

      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end

      if (accept && (cmd == CMD_HALT)) begin
        halted    <= 1'b1;
        exit_code <= bus.WDATA[15:0];
      end

      // Uses the registered HALTED, so characters queued before the halt
      // command are already counted in EMPTY.
      if (halted && empty && (state == IDLE) && bus.TX_READY) begin
        done <= 1'b1;
      end
    end
  end

  assign bus.TX_DATA   = tx_data;
  assign bus.TX_WE     = tx_we;
  assign bus.HALTED    = halted;
  assign bus.DONE      = done;
  assign bus.EXIT_CODE = exit_code;
  assign bus.FULL      = full;
  assign bus.EMPTY     = empty;
  assign bus.DROP_CNT  = drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tohost_console.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tohost_console
//  Purpose  : Self-checking bench for tohost_console: decode table, FIFO
//             full/drop boundaries, push/pop overlap, randomized streaming
//             against a queue model, halt/DONE ordering and mid-transfer reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tohost_console;

  localparam int QUEUE_SIZE = 64;
  localparam int CNT_W      = 16;

  logic CLK;
  logic RST_X;

  tohost_console_if #(.CNT_W(CNT_W)) bus ();

  tohost_console #(.QUEUE_SIZE(QUEUE_SIZE), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes accepted but not yet seen on TX, in order.
  logic [7:0]  exp_q[$];
  logic        m_halted;
  logic [15:0] m_exit;
  int          m_drop;

  // UART model controls
  bit hold_low = 1'b0;
  int busy_len = 0;
  int busy     = 0;
  int tx_count = 0;
  bit prev_we  = 1'b0;
  bit prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Decode rules applied to the model.
  task automatic model_write(input logic [31:0] d);
    if (!m_halted) begin
      case (d[17:16])
        2'd1: begin
          if (exp_q.size() >= QUEUE_SIZE) begin
            if (m_drop < 65535) m_drop++;
          end else begin
            exp_q.push_back(d[7:0]);
          end
        end
        2'd2: begin
          m_halted = 1'b1;
          m_exit   = d[15:0];
        end
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_halted = 1'b0;
    m_exit   = 16'h0;
    m_drop   = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [31:0] d);
    model_write(d);
    bus.WE    = 1'b1;
    bus.WDATA = d;
    tick();
    bus.WE    = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic reset_dut();
    RST_X    = 1'b0;
    hold_low = 1'b0;
    busy_len = 0;
    model_reset();
    ticks(2);
    RST_X = 1'b1;
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_we"},   bus.TX_WE,     0);
    chk({tag, "_tx_data"}, bus.TX_DATA,   0);
    chk({tag, "_halted"},  bus.HALTED,    0);
    chk({tag, "_done"},    bus.DONE,      0);
    chk({tag, "_exit"},    bus.EXIT_CODE, 0);
    chk({tag, "_drop"},    bus.DROP_CNT,  0);
    chk({tag, "_empty"},   bus.EMPTY,     1);
    chk({tag, "_full"},    bus.FULL,      0);
  endtask

  // UART TX model: records each strobe, then holds READY low for busy_len
  // cycles. READY only changes on the falling edge.
  always @(negedge CLK) begin
    if (!RST_X) begin
      busy      = 0;
      prev_we   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus.TX_WE) begin
        chk("we_while_not_ready", bus.TX_READY, 1);
        chk("we_back_to_back", prev_we, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_tx_byte", bus.TX_DATA, 32'hFFFF_FFFF);
        end else begin
          chk("tx_byte", bus.TX_DATA, exp_q.pop_front());
        end
        tx_count++;
        busy = busy_len;
      end else if (busy > 0) begin
        busy--;
      end
      prev_we = bus.TX_WE;
      if (bus.DONE && !prev_done) begin
        chk("done_before_drain", exp_q.size(), 0);
        chk("done_ready", bus.TX_READY, 1);
      end
      prev_done = bus.DONE;
    end
    bus.TX_READY = !hold_low && (busy == 0);
  end

  typedef struct {
    logic [31:0] wdata;
    logic        exp_empty;
    logic        exp_halted;
    logic [15:0] exp_exit;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    int          base;
    logic [31:0] rnd;
    logic [1:0]  cmd;

    vecs[0] = '{32'h0000_0041, 1'b1, 1'b0, 16'h0000};  // cmd 0 ignored
    vecs[1] = '{32'h0003_1234, 1'b1, 1'b0, 16'h0000};  // cmd 3 ignored
    vecs[2] = '{32'hFFFC_0055, 1'b1, 1'b0, 16'h0000};  // upper bits, cmd 0
    vecs[3] = '{32'h0001_0042, 1'b0, 1'b0, 16'h0000};  // print
    vecs[4] = '{32'h0002_00AB, 1'b0, 1'b1, 16'h00AB};  // halt
    vecs[5] = '{32'h0002_1111, 1'b0, 1'b1, 16'h00AB};  // halt after halt ignored
    vecs[6] = '{32'h0001_0043, 1'b0, 1'b1, 16'h00AB};  // print after halt ignored

    RST_X        = 1'b0;
    bus.WE       = 1'b0;
    bus.WDATA    = 32'h0;
    bus.TX_READY = 1'b0;
    model_reset();

    // ---- reset state ----
    ticks(3);
    chk_reset_outputs("reset");
    RST_X = 1'b1;
    ticks(2);

    // ---- single character latency ----
    bus.WE    = 1'b1;
    bus.WDATA = 32'h0001_0041;
    model_write(32'h0001_0041);
    tick();                                  // cycle N captured
    bus.WE = 1'b0;
    chk("lat_empty_n1", bus.EMPTY, 0);
    chk("lat_we_n1",    bus.TX_WE, 0);
    tick();
    chk("lat_we_n2",    bus.TX_WE, 1);
    chk("lat_data_n2",  bus.TX_DATA, 32'h41);
    chk("lat_empty_n2", bus.EMPTY, 1);
    tick();
    chk("lat_we_n3",    bus.TX_WE, 0);
    chk("lat_data_hold", bus.TX_DATA, 32'h41);
    wait_drain("lat_drain", 50);
    ticks(5);

    // ---- burst of 70 with READY held low ----
    hold_low = 1'b1;
    tick();
    for (int i = 0; i < 70; i++) begin
      wr(32'h0001_0000 | i);
      if (i == 62) chk("burst_not_full_63", bus.FULL, 0);
      if (i == 63) chk("burst_full_64", bus.FULL, 1);
    end
    chk("burst_drop", bus.DROP_CNT, m_drop);
    chk("burst_drop_6", bus.DROP_CNT, 6);
    // push on the very cycle of the first pop: FULL is pre-pop, so dropped
    hold_low = 1'b0;
    wr(32'h0001_00EE);
    chk("pop_cycle_drop", bus.DROP_CNT, 7);
    chk("pop_cycle_drop_model", bus.DROP_CNT, m_drop);
    wait_drain("burst_drain", 600);
    ticks(5);
    chk("burst_empty_after", bus.EMPTY, 1);

    // ---- push and pop in the same cycle at count 5 ----
    hold_low = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) wr(32'h0001_0060 + i);
    tick();
    hold_low = 1'b0;
    wr(32'h0001_0070);
    chk("pushpop_count", dut.count, 5);
    chk("pushpop_empty", bus.EMPTY, 0);
    wait_drain("pushpop_drain", 100);
    ticks(5);

    // ---- randomized stream against the queue model ----
    for (int k = 0; k < 240; k++) begin
      busy_len = ($urandom_range(0, 5) == 0) ? 20 : int'($urandom_range(0, 3));
      n = 0;
      while (exp_q.size() > 40 && n < 3000) begin
        tick();
        n++;
      end
      rnd = $urandom();
      case ($urandom_range(0, 4))
        0:       cmd = 2'd0;
        1:       cmd = 2'd3;
        default: cmd = 2'd1;
      endcase
      wr({rnd[31:18], cmd, rnd[15:0]});
      ticks($urandom_range(0, 5));
    end
    wait_drain("rand_drain", 6000);
    chk("rand_drop_unchanged", bus.DROP_CNT, m_drop);
    chk("rand_not_halted", bus.HALTED, 0);
    ticks(25);

    // ---- halt after three characters ----
    reset_dut();
    busy_len = 20;
    wr(32'h0001_0061);
    wr(32'h0001_0062);
    wr(32'h0001_0063);
    wr(32'h0002_002A);
    chk("halt_halted", bus.HALTED, 1);
    chk("halt_exit", bus.EXIT_CODE, 32'h2A);
    chk("halt_done_early", bus.DONE, 0);
    wr(32'h0001_0099);
    wr(32'h0002_0055);
    chk("halt_exit_kept", bus.EXIT_CODE, 32'h2A);
    n = 0;
    while (!bus.DONE && n < 400) begin
      tick();
      n++;
    end
    chk("halt_done", bus.DONE, 1);
    chk("halt_all_sent", exp_q.size(), 0);
    wr(32'h0001_0077);
    ticks(10);
    chk("halt_done_sticky", bus.DONE, 1);
    chk("halt_empty", bus.EMPTY, 1);

    // ---- decode table ----
    reset_dut();
    hold_low = 1'b1;
    tick();
    for (int v = 0; v < 7; v++) begin
      wr(vecs[v].wdata);
      chk($sformatf("dec%0d_empty", v),  bus.EMPTY,     vecs[v].exp_empty);
      chk($sformatf("dec%0d_halted", v), bus.HALTED,    vecs[v].exp_halted);
      chk($sformatf("dec%0d_exit", v),   bus.EXIT_CODE, vecs[v].exp_exit);
    end
    chk("dec_done_held", bus.DONE, 0);
    hold_low = 1'b0;
    wait_drain("dec_drain", 100);
    ticks(5);
    chk("dec_done", bus.DONE, 1);

    // ---- reset during WAIT with ten bytes queued ----
    reset_dut();
    busy_len = 60;
    for (int i = 0; i < 11; i++) wr(32'h0001_00A0 + i);
    ticks(12);
    chk("rst_mid_queued", bus.EMPTY, 0);
    #2;
    RST_X = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    model_reset();
    ticks(3);
    RST_X    = 1'b1;
    busy_len = 0;
    base     = tx_count;
    ticks(20);
    chk("rst_no_tx", tx_count - base, 0);
    wr(32'h0001_005A);
    wait_drain("rst_new_write", 50);
    chk("rst_one_tx", tx_count - base, 1);

    ticks(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
